// File: rtl/smpl_circuit_core.sv
// Combinational x/y gate network with registered copies, a saturating x-high counter
// and optional input-coverage tracking enabled by SMPL_CIRCUIT_COVER_EN.
module smpl_circuit_core #(
  parameter int CNT_W = 8
) (
  output logic             x,
  output logic             y,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             clk,
  input  logic             rst_n,
  output logic             x_q,
  output logic             y_q,
  output logic [CNT_W-1:0] x_cnt,
  output logic [7:0]       seen,
  output logic             all_seen
);

  logic             x_p1;
  logic             y_p1;
  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (v == {CNT_W{1'b1}}) ? v : v + one;
  endfunction

  // Continuous assigns keep plain gate X-propagation; no clock or reset involvement.
  assign x = (A & B) | ~C;
  assign y = ~C;

  // ---- stage p1: registered outputs and counter ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_p1   <= 1'b0;
      y_p1   <= 1'b0;
      cnt_p1 <= '0;
    end else begin
      x_p1 <= x;
      y_p1 <= y;
      if (x) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign x_q   = x_p1;
  assign y_q   = y_p1;
  assign x_cnt = cnt_p1;

`ifdef SMPL_CIRCUIT_COVER_EN
  logic [7:0] seen_p1;

  // Sticky mask: one bit per {A,B,C} combination observed at a clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) seen_p1 <= 8'h00;
    else        seen_p1 <= seen_p1 | (8'h01 << {A, B, C});
  end

  assign seen     = seen_p1;
  assign all_seen = (seen_p1 == 8'hFF);
`else
  assign seen     = 8'h00;
  assign all_seen = 1'b0;
`endif

endmodule

// File: tb/tb_smpl_circuit_core.sv
// Directed bench for smpl_circuit_core: truth table, latency, saturation,
// coverage mask and reset priority, using CNT_W=8 and CNT_W=2 instances.
module tb_smpl_circuit_core;

`ifdef SMPL_CIRCUIT_COVER_EN
  localparam bit COV = 1'b1;
`else
  localparam bit COV = 1'b0;
`endif

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n, A, B, C;

  logic       x8, y8, xq8, yq8, all8;
  logic [7:0] cnt8, seen8;
  logic       x2, y2, xq2, yq2, all2;
  logic [1:0] cnt2;
  logic [7:0] seen2;

  int vectors = 0;
  int fails   = 0;

  smpl_circuit_core #(.CNT_W(8)) dut8 (
    .x(x8), .y(y8), .A(A), .B(B), .C(C), .clk(clk), .rst_n(rst_n),
    .x_q(xq8), .y_q(yq8), .x_cnt(cnt8), .seen(seen8), .all_seen(all8)
  );

  smpl_circuit_core #(.CNT_W(2)) dut2 (
    .x(x2), .y(y2), .A(A), .B(B), .C(C), .clk(clk), .rst_n(rst_n),
    .x_q(xq2), .y_q(yq2), .x_cnt(cnt2), .seen(seen2), .all_seen(all2)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " xq8"},   {31'b0, xq8},  32'd0);
    check({tag, " yq8"},   {31'b0, yq8},  32'd0);
    check({tag, " cnt8"},  {24'b0, cnt8}, 32'd0);
    check({tag, " cnt2"},  {30'b0, cnt2}, 32'd0);
    check({tag, " seen8"}, {24'b0, seen8}, 32'd0);
    check({tag, " all8"},  {31'b0, all8}, 32'd0);
    check({tag, " xq2"},   {31'b0, xq2},  32'd0);
  endtask

  initial begin
    logic [7:0] xtab;
    logic [7:0] ytab;
    logic [2:0] abc;
    logic [7:0] exp_seen;
    xtab = 8'hD5;  // x for {A,B,C}=000..111 is 1,0,1,0,1,0,1,1
    ytab = 8'h55;  // y for {A,B,C}=000..111 is 1,0,1,0,1,0,1,0
    rst_n = 1'b0;
    {A, B, C} = 3'b000;

    // Truth table with the clock stopped
    for (int i = 0; i < 8; i++) begin
      abc = i[2:0];
      {A, B, C} = abc;
      #25;
      check($sformatf("tt x8[%0d]", i), {31'b0, x8}, {31'b0, xtab[i]});
      check($sformatf("tt y8[%0d]", i), {31'b0, y8}, {31'b0, ytab[i]});
      check($sformatf("tt x2[%0d]", i), {31'b0, x2}, {31'b0, xtab[i]});
    end

    // Reset held for two edges while x=1: reset wins
    clk_en = 1'b1;
    {A, B, C} = 3'b110;
    tick();
    tick();
    check_reset_state("rst");

    // Release: combinational outputs are immediate, registered ones one edge later
    rst_n = 1'b1;
    #1;
    check("lat x immediate", {31'b0, x8}, 32'd1);
    check("lat y immediate", {31'b0, y8}, 32'd1);
    check("lat xq before edge", {31'b0, xq8}, 32'd0);
    tick();
    check("lat xq", {31'b0, xq8}, 32'd1);
    check("lat yq", {31'b0, yq8}, 32'd1);
    check("cnt8 e1", {24'b0, cnt8}, 32'd1);
    check("cnt2 e1", {30'b0, cnt2}, 32'd1);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check($sformatf("cnt2 e%0d", k), {30'b0, cnt2}, (k > 3) ? 32'd3 : k);
      check($sformatf("cnt8 e%0d", k), {24'b0, cnt8}, k);
    end
    exp_seen = COV ? 8'h40 : 8'h00;
    check("seen8 single", {24'b0, seen8}, {24'b0, exp_seen});
    check("all8 single", {31'b0, all8}, 32'd0);

    // Drive the 8-bit counter well past its ceiling
    for (int k = 0; k < 255; k++) tick();
    check("cnt8 sat", {24'b0, cnt8}, 32'd255);
    check("cnt2 sat", {30'b0, cnt2}, 32'd3);

    // Coverage walk after a fresh reset
    rst_n = 1'b0;
    tick();
    check_reset_state("rst2");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      abc = i[2:0];
      {A, B, C} = abc;
      tick();
      exp_seen = COV ? 8'((16'h1 << (i + 1)) - 16'h1) : 8'h00;
      check($sformatf("cov seen8[%0d]", i), {24'b0, seen8}, {24'b0, exp_seen});
      check($sformatf("cov seen2[%0d]", i), {24'b0, seen2}, {24'b0, exp_seen});
      check($sformatf("cov all8[%0d]", i), {31'b0, all8}, {31'b0, COV && (i == 7)});
      check($sformatf("cov xq8[%0d]", i), {31'b0, xq8}, {31'b0, xtab[i]});
      check($sformatf("cov yq8[%0d]", i), {31'b0, yq8}, {31'b0, ytab[i]});
    end
    check("cov cnt8", {24'b0, cnt8}, 32'd5);
    check("cov cnt2", {30'b0, cnt2}, 32'd3);
    check("cov all2", {31'b0, all2}, {31'b0, COV});

    // Reset with x=1, counter saturated and mask full
    {A, B, C} = 3'b111;
    rst_n = 1'b0;
    tick();
    check_reset_state("prio");
    check("prio all2", {31'b0, all2}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("resume cnt8", {24'b0, cnt8}, 32'd1);
    check("resume cnt2", {30'b0, cnt2}, 32'd1);
    check("resume xq8", {31'b0, xq8}, 32'd1);
    check("resume yq8", {31'b0, yq8}, 32'd0);
    exp_seen = COV ? 8'h80 : 8'h00;
    check("resume seen8", {24'b0, seen8}, {24'b0, exp_seen});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/smpl_circuit_core.md
SMPL_CIRCUIT_CORE -- requirements
Module: smpl_circuit

Interface
REQ-001 SHALL have one parameter: CNT_W, default 8, width of the x-high cycle counter (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: x  output  1  combinational output, (A AND B) OR (NOT C).
REQ-005 SHALL have port: y  output  1  combinational output, NOT C.
REQ-006 SHALL have port: A  input  1  data input.
REQ-007 SHALL have port: B  input  1  data input.
REQ-008 SHALL have port: C  input  1  data input.
REQ-009 SHALL have port: x_q  output  1  registered copy of x.
REQ-010 SHALL have port: y_q  output  1  registered copy of y.
REQ-011 SHALL have port: x_cnt  output  CNT_W  saturating count of clock edges sampled with x=1.
REQ-012 SHALL have port: seen  output  8  input-combination coverage mask; bit index = {A,B,C}.
REQ-013 SHALL have port: all_seen  output  1  high when seen = 8'hFF.
REQ-014 SHALL declare ports in the order x, y, A, B, C, clk, rst_n, x_q, y_q, x_cnt, seen, all_seen, so that a positional connection of the first five ports stays valid.

Function
REQ-015 SHALL drive x and y purely combinationally from A, B and C, with no dependence on clk or rst_n.
REQ-016 SHALL produce this x/y truth table for {A,B,C} = 000..111: x = 1,0,1,0,1,0,1,1; y = 1,0,1,0,1,0,1,0.
REQ-017 SHALL drive x and y to X whenever any of A, B, C is X or Z (plain gate semantics, no masking).
REQ-018 SHALL register x into x_q and y into y_q on every rising clk edge while rst_n=1, giving one-cycle latency.
REQ-019 SHALL increment x_cnt by 1 on each rising edge where rst_n=1 and x=1.
REQ-020 SHALL hold x_cnt at 2^CNT_W-1 once it reaches that value, with no wrap-around.
REQ-021 SHALL set seen[{A,B,C}] on each rising edge where rst_n=1; once set, a bit stays set until reset.
REQ-022 SHALL drive all_seen combinationally from the seen register.
REQ-023 SHALL give reset priority over every update in the same cycle.

Reset
REQ-024 SHALL clear x_q, y_q, x_cnt and seen to 0 on a rising edge with rst_n=0; all_seen then reads 0.
REQ-025 SHALL NOT reset x and y; they follow the inputs during reset.
REQ-026 SHALL make reset asserted mid-operation (for example while x_cnt is saturated or all_seen=1) clear the state on the next edge, with counting resuming on the first edge after rst_n returns to 1.

Configuration
REQ-027 SHALL compile the coverage logic (seen register, all_seen) only when the macro SMPL_CIRCUIT_COVER_EN is defined.
REQ-028 SHALL keep the seen and all_seen ports when SMPL_CIRCUIT_COVER_EN is undefined, tied to constant 0, with no seen register present; all other behaviour is unchanged.

Verification
REQ-029 SHALL cover the following directed scenarios:
- Scenario 1 (truth table): step {A,B,C} through 000..111 in 25 ns steps with no clock -> x = 1,0,1,0,1,0,1,1 and y = 1,0,1,0,1,0,1,0 after each step.
- Scenario 2 (latency): hold rst_n=0 for 2 edges, then set {A,B,C}=110 -> x=1 and y=1 immediately; x_q=1 and y_q=1 after the next rising edge.
- Scenario 3 (counter): CNT_W=2, hold C=0 for 5 edges after reset -> x_cnt sequence 1,2,3,3,3.
- Scenario 4 (coverage): with the macro defined, apply each {A,B,C} for one edge in order 000..111 -> seen=8'h01,8'h03,...,8'hFF and all_seen=1 after the eighth edge; without the macro, seen=0 and all_seen=0 throughout.
- Scenario 5 (reset priority): with x=1 and rst_n=0 on the same edge -> x_cnt=0, x_q=0, seen=0.
